// File: rtl/store_size_unit.sv
// Multicycle MIPS store path: merges register B into the addressed word (SW/SH/SB) via read-modify-write.
// Optional STORE_SIZE_MISALIGN_CHK_EN rejects misaligned/illegal requests through the ERR state.
module store_size_unit #(
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  SSControl,
   input  logic [31:0] addr,
   input  logic [31:0] B_out,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;
   localparam logic [1:0]  SS_SW  = 2'b00;
   localparam logic [1:0]  SS_SH  = 2'b01;
   localparam logic [1:0]  SS_SB  = 2'b10;
   localparam logic [1:0]  SS_ILL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_WR,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q;
   logic [1:0]      lane_q;
   logic            byte_q;
   logic [15:0]     b_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   merged_d;
   logic            req_err_c;
   logic            req_word_c;

   // Request classification, evaluated on the live inputs while IDLE.
   always_comb begin
      req_err_c  = 1'b0;
`ifdef STORE_SIZE_MISALIGN_CHK_EN
      req_err_c  = (SSControl == SS_ILL)
                || ((SSControl == SS_SH) && addr[0])
                || ((SSControl == SS_SW) && (addr[1:0] != 2'b00));
`endif
      req_word_c = (SSControl == SS_SW) || (SSControl == SS_ILL);
   end

   // Little-endian lane merge of latched store data into the read word.
   always_comb begin
      merged_d = mem_rdata;
      if (byte_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (lane_q == 2'(i)) merged_d[8*i +: 8] = b_q[7:0];
         end
      end else if (lane_q[1]) begin
         merged_d[31:16] = b_q;
      end else begin
         merged_d[15:0] = b_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         lane_q    <= 2'b00;
         byte_q    <= 1'b0;
         b_q       <= '0;
         cnt_q     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_wr <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lane_q <= addr[1:0];
                  byte_q <= (SSControl == SS_SB);
                  b_q    <= B_out[15:0];
                  busy   <= 1'b1;
                  if (req_err_c) begin
                     state_q <= S_ERR;
                     err     <= 1'b1;
                  end else if (req_word_c) begin
                     // Full word needs no read: write straight away.
                     state_q   <= S_WR;
                     mem_wr    <= 1'b1;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_wdata <= B_out;
                  end else begin
                     state_q  <= S_RD;
                     mem_addr <= {addr[31:2], 2'b00};
                  end
               end
            end
            S_RD: begin
               state_q <= S_WT;
               cnt_q   <= CW'(MEM_RD_LAT - 1);
            end
            S_WT: begin
               if (cnt_q == '0) begin
                  state_q   <= S_WR;
                  mem_wr    <= 1'b1;
                  mem_wdata <= merged_d;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_WR: begin
               state_q  <= S_DONE;
               done     <= 1'b1;
               mem_addr <= '0;
            end
            S_DONE, S_ERR: begin
               state_q <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               busy     <= 1'b0;
               mem_addr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: two instances (read latency 1 and 3) against a word-array reference model.
module tb_store_size_unit;

   localparam bit CHK_EN =
`ifdef STORE_SIZE_MISALIGN_CHK_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start [2];
   logic [1:0]  ss    [2];
   logic [31:0] addr  [2];
   logic [31:0] bdat  [2];
   logic [31:0] rdata [2];
   logic [31:0] maddr [2];
   logic [31:0] wdata [2];
   logic        wr    [2];
   logic        busy  [2];
   logic        done  [2];
   logic        err   [2];

   logic [31:0] mem     [2][256];
   logic [31:0] ref_mem [2][256];
   logic [7:0]  pa      [2][4];
   logic        pv      [2][4];
   logic [31:0] noise   [2];
   logic        pre_en;
   int          pre_k;
   logic [7:0]  pre_idx;
   logic [31:0] pre_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_size_unit #(.MEM_RD_LAT(1)) u_l1 (
      .clk(clk), .reset(reset), .start(start[0]), .SSControl(ss[0]), .addr(addr[0]),
      .B_out(bdat[0]), .mem_rdata(rdata[0]), .mem_addr(maddr[0]), .mem_wr(wr[0]),
      .mem_wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   store_size_unit #(.MEM_RD_LAT(3)) u_l3 (
      .clk(clk), .reset(reset), .start(start[1]), .SSControl(ss[1]), .addr(addr[1]),
      .B_out(bdat[1]), .mem_rdata(rdata[1]), .mem_addr(maddr[1]), .mem_wr(wr[1]),
      .mem_wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Memory: writes on strobe, read data valid L cycles after the address, noise otherwise.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pre_en && pre_k == k) mem[k][pre_idx] <= pre_val;
         else if (wr[k] === 1'b1) mem[k][maddr[k][9:2]] <= wdata[k];
         for (int i = 3; i > 0; i--) begin
            pa[k][i] <= pa[k][i-1];
            pv[k][i] <= pv[k][i-1];
         end
         pa[k][0] <= maddr[k][9:2];
         pv[k][0] <= (busy[k] === 1'b1);
         noise[k] <= $urandom;
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         rdata[k] = pv[k][lat_of(k)-1] ? mem[k][pa[k][lat_of(k)-1]] : noise[k];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preset(input int k, input logic [7:0] idx, input logic [31:0] val);
      ref_mem[k][idx] = val;
      pre_en = 1'b1; pre_k = k; pre_idx = idx; pre_val = val;
      step();
      pre_en = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag, input int k);
      chk({tag, "_wr"},    32'(wr[k]),   32'h0);
      chk({tag, "_done"},  32'(done[k]), 32'h0);
      chk({tag, "_err"},   32'(err[k]),  32'h0);
      chk({tag, "_busy"},  32'(busy[k]), 32'h0);
      chk({tag, "_addr"},  maddr[k],     32'h0);
      chk({tag, "_wdata"}, wdata[k],     32'h0);
   endtask

   // One store on instance k, checked every cycle until the first IDLE cycle after completion.
   task automatic run_store(input int k, input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] b, input int poke);
      int          l, wr_c, end_c, idle_c, sh;
      bit          e, word;
      logic [31:0] w, old, exp;
      string       t;
      l    = lat_of(k);
      e    = CHK_EN && (s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b00 && a[1:0] != 2'b00));
      word = (s == 2'b00) || (s == 2'b11);
      w    = {a[31:2], 2'b00};
      old  = ref_mem[k][a[9:2]];
      if (word) begin
         exp = b;
      end else if (s == 2'b10) begin
         sh  = 8 * int'(a[1:0]);
         exp = (old & ~(32'h0000_00FF << sh)) | ({24'h0, b[7:0]} << sh);
      end else begin
         sh  = 16 * int'(a[1]);
         exp = (old & ~(32'h0000_FFFF << sh)) | ({16'h0, b[15:0]} << sh);
      end
      wr_c   = e ? -1 : (word ? 1 : l + 2);
      end_c  = e ? 1 : wr_c + 1;
      idle_c = end_c + 1;
      start[k] = 1'b1; ss[k] = s; addr[k] = a; bdat[k] = b;
      for (int c = 1; c <= idle_c; c++) begin
         step();
         start[k] = (c == poke) && (c < idle_c);
         ss[k] = 2'($urandom); addr[k] = $urandom; bdat[k] = $urandom;
         t = $sformatf("k%0d_a%h_s%0d_c%0d", k, a, s, c);
         chk({t, "_wr"},   32'(wr[k]),   32'(c == wr_c));
         chk({t, "_done"}, 32'(done[k]), 32'(!e && c == end_c));
         chk({t, "_err"},  32'(err[k]),  32'(e && c == end_c));
         chk({t, "_busy"}, 32'(busy[k]), 32'(c < idle_c));
         if (c == wr_c) chk({t, "_wdata"}, wdata[k], exp);
         if (!e && (c == wr_c || (!word && c <= l + 1))) chk({t, "_addr"}, maddr[k], w);
         if (c == idle_c) chk({t, "_addr0"}, maddr[k], 32'h0);
      end
      start[k] = 1'b0;
      if (!e) ref_mem[k][a[9:2]] = exp;
   endtask

   initial begin
      reset  = 1'b0;
      pre_en = 1'b0; pre_k = 0; pre_idx = '0; pre_val = '0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; ss[k] = '0; addr[k] = '0; bdat[k] = '0;
      end
      // Reset held with random inputs while memory is filled.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i++) begin
            start[k] = 1'($urandom); ss[k] = 2'($urandom); addr[k] = $urandom; bdat[k] = $urandom;
            preset(k, 8'(i), $urandom);
         end
      end
      for (int n = 0; n < 2; n++) begin
         step();
         for (int k = 0; k < 2; k++) chk_idle_zero($sformatf("reset%0d_k%0d", n, k), k);
      end
      for (int k = 0; k < 2; k++) start[k] = 1'b0;
      reset = 1'b1;
      step();

      // Directed cases.
      run_store(0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 0);
      preset(0, 8'h04, 32'h1122_3344);
      run_store(0, 2'b10, 32'h0000_0013, 32'h0000_00AB, 0);
      preset(1, 8'h08, 32'h5566_7788);
      run_store(1, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 3);
      run_store(0, 2'b01, 32'h0000_0021, 32'h1234_5678, 0);
      run_store(1, 2'b01, 32'h0000_0021, 32'h9ABC_DEF0, 0);
      run_store(0, 2'b11, 32'h0000_0044, 32'h0BAD_F00D, 0);
      run_store(1, 2'b00, 32'h0000_0047, 32'hFEED_FACE, 0);
      run_store(1, 2'b10, 32'h0000_0040, 32'hFFFF_FF5A, 0);

      // Reset in the middle of a byte store.
      start[0] = 1'b1; ss[0] = 2'b10; addr[0] = 32'h0000_0031; bdat[0] = $urandom;
      step();
      start[0] = 1'b0;
      chk("rstmid_busy1", 32'(busy[0]), 32'h1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) chk_idle_zero($sformatf("rstmid_k%0d", k), k);
      for (int n = 0; n < 5; n++) begin
         step();
         chk($sformatf("rstmid_nowr%0d", n), 32'(wr[0]), 32'h0);
         chk($sformatf("rstmid_idle%0d", n), 32'(busy[0]), 32'h0);
      end
      chk("rstmid_mem", mem[0][8'h0C], ref_mem[0][8'h0C]);
      run_store(0, 2'b00, 32'h0000_0030, 32'hA5A5_5A5A, 0);

      // Randomized back-to-back stores on both latencies.
      for (int n = 0; n < 40; n++) begin
         run_store(n % 2, 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)));
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i += 17) chk($sformatf("mem_k%0d_%0d", k, i), mem[k][i], ref_mem[k][i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
